// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the four-key debouncer: key count, code width,
// capture FSM states and the lowest-index priority pick.
package key_pkg;

    localparam int NUM_KEYS   = 4;
    localparam int KEY_CODE_W = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cap_state_t;

    // bit0 (in1) has the highest priority
    function automatic logic [KEY_CODE_W-1:0] pick_lowest(input logic [NUM_KEYS-1:0] req);
        logic [KEY_CODE_W-1:0] code;
        code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (req[i]) code = KEY_CODE_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debouncer_debounce_channel.sv
// One button channel: multi-flop synchronizer, stability counter, and the
// registered debounced level with its press pulse.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_WIDTH-1:0]   cnt;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            pulse  <= 1'b0;
            // a sample matching the current level restarts the count
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                pulse <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Four debounced push-buttons feeding a priority encoder, plus a held key
// event (valid/ack) with sticky overrun for edge-driven consumers.
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_KEYS-1:0]   btn_raw,
    output logic [NUM_KEYS-1:0]   btn_level,
    output logic [NUM_KEYS-1:0]   press_pulse,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_overrun,
    input  logic                  key_ack
);

    // Handshake: key_valid stays high with key_code stable until a cycle with
    // key_ack = 1; that cycle's edge retires the event (or replaces it when a
    // press pulse arrives in the same cycle). key_ack while idle is ignored.

    cap_state_t            state_q, state_d;
    logic [KEY_CODE_W-1:0] code_q, code_d;
    logic                  ovr_q, ovr_d;
    logic                  any_press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (press_pulse[i])
        );
    end

    assign any_press = |press_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (any_press) begin
                    state_d = PENDING;
                    code_d  = pick_lowest(press_pulse);
                end
            end
            PENDING: begin
                if (key_ack) begin
                    ovr_d = 1'b0;
                    if (any_press) code_d = pick_lowest(press_pulse);
                    else           state_d = IDLE;
                end else if (any_press) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_valid   = (state_q == PENDING);
    assign key_code    = code_q;
    assign key_overrun = ovr_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2
// (raw step to level latency is 6 cycles).
module tb_key_debouncer;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_overrun;
    logic       key_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt;

    key_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (16),
        .SYNC_STAGES     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_overrun (key_overrun),
        .key_ack     (key_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one edge and settle just after it
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_event(input string tag, input logic v, input logic [1:0] c, input logic o);
        check({tag, "_valid"}, {7'd0, key_valid}, {7'd0, v});
        check({tag, "_code"}, {6'd0, key_code}, {6'd0, c});
        check({tag, "_ovr"}, {7'd0, key_overrun}, {7'd0, o});
    endtask

    task automatic do_ack;
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 4'b1111;
        key_ack = 1'b0;

        // reset held 3 cycles with all buttons pressed
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_level", {4'd0, btn_level}, 8'h00);
            check("rst_pulse", {4'd0, press_pulse}, 8'h00);
            check_event("rst", 1'b0, 2'd0, 1'b0);
        end
        rst_n = 1'b1;
        tick(5);
        check("rel_level_early", {4'd0, btn_level}, 8'h00);
        tick(1);
        check("rel_level", {4'd0, btn_level}, 8'h0f);
        check("rel_pulse", {4'd0, press_pulse}, 8'h0f);
        tick(1);
        check("rel_pulse_off", {4'd0, press_pulse}, 8'h00);
        check_event("rel_evt", 1'b1, 2'd0, 1'b0);
        do_ack();
        check_event("rel_ack", 1'b0, 2'd0, 1'b0);

        // release all: no pulse on 1->0
        btn_raw = 4'b0000;
        pulse_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (press_pulse != 4'b0000) pulse_cnt++;
        end
        check("release_level", {4'd0, btn_level}, 8'h00);
        check("release_nopulse", pulse_cnt[7:0], 8'd0);
        check("release_idle", {7'd0, key_valid}, 8'd0);

        // ack while idle is ignored
        do_ack();
        check_event("idle_ack", 1'b0, 2'd0, 1'b0);

        // clean press on key 2
        btn_raw = 4'b0100;
        tick(5);
        check("clean_early", {4'd0, btn_level}, 8'h00);
        tick(1);
        check("clean_level", {4'd0, btn_level}, 8'h04);
        check("clean_pulse", {4'd0, press_pulse}, 8'h04);
        check("clean_novalid", {7'd0, key_valid}, 8'd0);
        tick(1);
        check("clean_pulse_off", {4'd0, press_pulse}, 8'h00);
        check_event("clean_evt", 1'b1, 2'd2, 1'b0);
        do_ack();
        check_event("clean_ack", 1'b0, 2'd2, 1'b0);
        btn_raw = 4'b0000;
        tick(6);
        check("clean_release", {4'd0, btn_level}, 8'h00);

        // bounce on key 0, then held
        pulse_cnt = 0;
        btn_raw = 4'b0001; tick(1);
        if (press_pulse != 4'b0000) pulse_cnt++;
        btn_raw = 4'b0000; tick(1);
        if (press_pulse != 4'b0000) pulse_cnt++;
        btn_raw = 4'b0001; tick(1);
        if (press_pulse != 4'b0000) pulse_cnt++;
        btn_raw = 4'b0000; tick(1);
        if (press_pulse != 4'b0000) pulse_cnt++;
        btn_raw = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (press_pulse != 4'b0000) pulse_cnt++;
        end
        check("bounce_early", {4'd0, btn_level}, 8'h00);
        tick(1);
        if (press_pulse != 4'b0000) pulse_cnt++;
        check("bounce_level", {4'd0, btn_level}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (press_pulse != 4'b0000) pulse_cnt++;
        end
        check("bounce_one_pulse", pulse_cnt[7:0], 8'd1);
        check_event("bounce_evt", 1'b1, 2'd0, 1'b0);
        do_ack();
        btn_raw = 4'b0000;
        tick(6);
        check("bounce_release", {4'd0, btn_level}, 8'h00);

        // simultaneous keys 1 and 3: key 1 wins, no overrun
        btn_raw = 4'b1010;
        tick(6);
        check("simul_pulse", {4'd0, press_pulse}, 8'h0a);
        tick(1);
        check_event("simul_evt", 1'b1, 2'd1, 1'b0);
        do_ack();
        check_event("simul_ack", 1'b0, 2'd1, 1'b0);
        btn_raw = 4'b0000;
        tick(6);

        // overrun then ack colliding with a new press
        btn_raw = 4'b0010;
        tick(7);
        check_event("ovr_first", 1'b1, 2'd1, 1'b0);
        btn_raw = 4'b1010;
        tick(6);
        check("ovr_pulse3", {4'd0, press_pulse}, 8'h08);
        tick(1);
        check_event("ovr_set", 1'b1, 2'd1, 1'b1);
        btn_raw = 4'b1011;
        tick(6);
        check("coll_pulse0", {4'd0, press_pulse}, 8'h01);
        do_ack();
        check_event("coll_evt", 1'b1, 2'd0, 1'b0);
        do_ack();
        check_event("coll_ack", 1'b0, 2'd0, 1'b0);
        btn_raw = 4'b0000;
        tick(6);
        check("coll_release", {4'd0, btn_level}, 8'h00);

        // reset at count 2 of a key-3 press
        btn_raw = 4'b1000;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("midrst_level", {4'd0, btn_level}, 8'h00);
        check_event("midrst", 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick(5);
        check("midrst_early", {4'd0, btn_level}, 8'h00);
        tick(1);
        check("midrst_level_up", {4'd0, btn_level}, 8'h08);
        check("midrst_pulse", {4'd0, press_pulse}, 8'h08);
        tick(1);
        check_event("midrst_evt", 1'b1, 2'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
